// File: rtl/order_matcher.sv
// order_matcher: single-level limit-order matcher.
// Holds one best bid and one best ask with their quantities. It accepts orders over a
// valid/ready handshake. When the book crosses, it emits a one-cycle trade pulse with the
// trade prices and quantity.
// Empty-side sentinels: bid 8'h00 = empty, ask 8'hFF = empty.
// Optional build macro ORDER_CANCEL_EN adds cancel_valid/cancel_side. A cancel clears one
// side while the matcher is idle and takes priority over a simultaneous order.
module order_matcher #(
    parameter int QTY_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             order_valid,
    output logic             order_ready,
    input  logic             order_side,
    input  logic [7:0]       order_price,
    input  logic [QTY_W-1:0] order_qty,
`ifdef ORDER_CANCEL_EN
    input  logic             cancel_valid,
    input  logic             cancel_side,
`endif
    output logic             match_signal,
    output logic [7:0]       buy_price,
    output logic [7:0]       sell_price,
    output logic [QTY_W-1:0] match_qty,
    output logic [7:0]       best_bid,
    output logic [7:0]       best_ask,
    output logic [QTY_W-1:0] bid_qty,
    output logic [QTY_W-1:0] ask_qty,
    output logic [CNT_W-1:0] match_count,
    output logic [7:0]       reject_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_MATCH = 2'd2;

    localparam logic [7:0]       BID_EMPTY = 8'h00;
    localparam logic [7:0]       ASK_EMPTY = 8'hFF;
    localparam logic [QTY_W-1:0] QTY_ZERO  = {QTY_W{1'b0}};
    localparam logic [QTY_W-1:0] QTY_MAX   = {QTY_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       REJ_MAX   = 8'hFF;

    // Unsigned add that clamps at the all-ones value instead of wrapping.
    function automatic logic [QTY_W-1:0] qty_sat_add(input logic [QTY_W-1:0] a,
                                                     input logic [QTY_W-1:0] b);
        logic [QTY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[QTY_W]) begin
            qty_sat_add = QTY_MAX;
        end else begin
            qty_sat_add = sum[QTY_W-1:0];
        end
    endfunction

    // Smaller of two quantities; this is the size of a trade.
    function automatic logic [QTY_W-1:0] qty_min(input logic [QTY_W-1:0] a,
                                                 input logic [QTY_W-1:0] b);
        if (a < b) begin
            qty_min = a;
        end else begin
            qty_min = b;
        end
    endfunction

    // Architectural state
    logic [1:0]       state_r;
    logic [7:0]       best_bid_r;
    logic [7:0]       best_ask_r;
    logic [QTY_W-1:0] bid_qty_r;
    logic [QTY_W-1:0] ask_qty_r;
    logic [7:0]       buy_price_r;
    logic [7:0]       sell_price_r;
    logic [QTY_W-1:0] match_qty_r;
    logic             match_signal_r;
    logic [CNT_W-1:0] match_count_r;
    logic [7:0]       reject_count_r;

    // Next-state values
    logic [1:0]       state_s;
    logic [7:0]       best_bid_s;
    logic [7:0]       best_ask_s;
    logic [QTY_W-1:0] bid_qty_s;
    logic [QTY_W-1:0] ask_qty_s;
    logic [7:0]       buy_price_s;
    logic [7:0]       sell_price_s;
    logic [QTY_W-1:0] match_qty_s;
    logic             match_signal_s;
    logic [CNT_W-1:0] match_count_s;
    logic [7:0]       reject_count_s;

    logic             cancel_req_s;
    logic             cancel_sel_s;
    logic             order_ready_s;
    logic             handshake_s;
    logic             reject_s;
    logic             crossed_s;
    logic [QTY_W-1:0] bid_left_s;
    logic [QTY_W-1:0] ask_left_s;

`ifdef ORDER_CANCEL_EN
    assign cancel_req_s = cancel_valid;
    assign cancel_sel_s = cancel_side;
`else
    assign cancel_req_s = 1'b0;
    assign cancel_sel_s = 1'b0;
`endif

    // A cancel in IDLE blocks the handshake so that the order stays offered for the next cycle.
    assign order_ready_s = reset & (state_r == ST_IDLE) & ~cancel_req_s;
    assign handshake_s   = order_valid & order_ready_s;
    assign crossed_s     = (best_bid_r != BID_EMPTY) && (best_ask_r != ASK_EMPTY) &&
                           (best_bid_r >= best_ask_r);
    assign bid_left_s    = bid_qty_r - match_qty_r;
    assign ask_left_s    = ask_qty_r - match_qty_r;

    // Next-state computation for the book, trade outputs and counters.
    always_comb begin
        state_s        = state_r;
        best_bid_s     = best_bid_r;
        best_ask_s     = best_ask_r;
        bid_qty_s      = bid_qty_r;
        ask_qty_s      = ask_qty_r;
        buy_price_s    = buy_price_r;
        sell_price_s   = sell_price_r;
        match_qty_s    = match_qty_r;
        match_signal_s = 1'b0;
        match_count_s  = match_count_r;
        reject_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cancel_req_s) begin
                    if (cancel_sel_s == 1'b0) begin
                        best_bid_s = BID_EMPTY;
                        bid_qty_s  = QTY_ZERO;
                    end else begin
                        best_ask_s = ASK_EMPTY;
                        ask_qty_s  = QTY_ZERO;
                    end
                end else if (handshake_s) begin
                    if (order_qty == QTY_ZERO) begin
                        reject_s = 1'b1;
                    end else if (order_side == 1'b0) begin
                        // Buy: a higher price improves the bid
                        if (order_price == BID_EMPTY) begin
                            reject_s = 1'b1;
                        end else if ((best_bid_r == BID_EMPTY) || (order_price > best_bid_r)) begin
                            best_bid_s = order_price;
                            bid_qty_s  = order_qty;
                            state_s    = ST_CHECK;
                        end else if (order_price == best_bid_r) begin
                            bid_qty_s  = qty_sat_add(bid_qty_r, order_qty);
                            state_s    = ST_CHECK;
                        end else begin
                            reject_s = 1'b1;
                        end
                    end else begin
                        // Sell: a lower price improves the ask
                        if (order_price == ASK_EMPTY) begin
                            reject_s = 1'b1;
                        end else if ((best_ask_r == ASK_EMPTY) || (order_price < best_ask_r)) begin
                            best_ask_s = order_price;
                            ask_qty_s  = order_qty;
                            state_s    = ST_CHECK;
                        end else if (order_price == best_ask_r) begin
                            ask_qty_s  = qty_sat_add(ask_qty_r, order_qty);
                            state_s    = ST_CHECK;
                        end else begin
                            reject_s = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (crossed_s) begin
                    // Register the trade so that it is visible together with the pulse in MATCH
                    state_s        = ST_MATCH;
                    match_signal_s = 1'b1;
                    buy_price_s    = best_bid_r;
                    sell_price_s   = best_ask_r;
                    match_qty_s    = qty_min(bid_qty_r, ask_qty_r);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_MATCH: begin
                // Fill both sides; a side that is fully consumed reverts to its sentinel
                bid_qty_s     = bid_left_s;
                ask_qty_s     = ask_left_s;
                if (bid_left_s == QTY_ZERO) begin
                    best_bid_s = BID_EMPTY;
                end else begin
                    best_bid_s = best_bid_r;
                end
                if (ask_left_s == QTY_ZERO) begin
                    best_ask_s = ASK_EMPTY;
                end else begin
                    best_ask_s = best_ask_r;
                end
                match_count_s = match_count_r + CNT_ONE;
                state_s       = ST_CHECK;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (reject_s && (reject_count_r != REJ_MAX)) begin
            reject_count_s = reject_count_r + 8'd1;
        end else begin
            reject_count_s = reject_count_r;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            best_bid_r     <= BID_EMPTY;
            best_ask_r     <= ASK_EMPTY;
            bid_qty_r      <= QTY_ZERO;
            ask_qty_r      <= QTY_ZERO;
            buy_price_r    <= 8'h00;
            sell_price_r   <= 8'h00;
            match_qty_r    <= QTY_ZERO;
            match_signal_r <= 1'b0;
            match_count_r  <= CNT_ZERO;
            reject_count_r <= 8'h00;
        end else begin
            state_r        <= state_s;
            best_bid_r     <= best_bid_s;
            best_ask_r     <= best_ask_s;
            bid_qty_r      <= bid_qty_s;
            ask_qty_r      <= ask_qty_s;
            buy_price_r    <= buy_price_s;
            sell_price_r   <= sell_price_s;
            match_qty_r    <= match_qty_s;
            match_signal_r <= match_signal_s;
            match_count_r  <= match_count_s;
            reject_count_r <= reject_count_s;
        end
    end

    assign order_ready  = order_ready_s;
    assign match_signal = match_signal_r;
    assign buy_price    = buy_price_r;
    assign sell_price   = sell_price_r;
    assign match_qty    = match_qty_r;
    assign best_bid     = best_bid_r;
    assign best_ask     = best_ask_r;
    assign bid_qty      = bid_qty_r;
    assign ask_qty      = ask_qty_r;
    assign match_count  = match_count_r;
    assign reject_count = reject_count_r;

endmodule

// File: tb/tb_order_matcher.sv
// Directed testbench for order_matcher with hand-computed expected values.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that point.
module tb_order_matcher;

    logic        clk;
    logic        reset;
    logic        order_valid;
    logic        order_ready;
    logic        order_side;
    logic [7:0]  order_price;
    logic [7:0]  order_qty;
`ifdef ORDER_CANCEL_EN
    logic        cancel_valid;
    logic        cancel_side;
`endif
    logic        match_signal;
    logic [7:0]  buy_price;
    logic [7:0]  sell_price;
    logic [7:0]  match_qty;
    logic [7:0]  best_bid;
    logic [7:0]  best_ask;
    logic [7:0]  bid_qty;
    logic [7:0]  ask_qty;
    logic [15:0] match_count;
    logic [7:0]  reject_count;

    int vectors;
    int miscompares;

    order_matcher #(.QTY_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .order_side   (order_side),
        .order_price  (order_price),
        .order_qty    (order_qty),
`ifdef ORDER_CANCEL_EN
        .cancel_valid (cancel_valid),
        .cancel_side  (cancel_side),
`endif
        .match_signal (match_signal),
        .buy_price    (buy_price),
        .sell_price   (sell_price),
        .match_qty    (match_qty),
        .best_bid     (best_bid),
        .best_ask     (best_ask),
        .bid_qty      (bid_qty),
        .ask_qty      (ask_qty),
        .match_count  (match_count),
        .reject_count (reject_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one order for a single cycle; it is consumed on the next edge
    task automatic send(input logic side, input logic [7:0] price, input logic [7:0] qty);
        order_valid = 1'b1;
        order_side  = side;
        order_price = price;
        order_qty   = qty;
        #1;
        chk("ready_before_send", {31'd0, order_ready}, 32'd1);
        @(posedge clk);
        #1;
        order_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        order_valid = 1'b0;
        order_side  = 1'b0;
        order_price = 8'h00;
        order_qty   = 8'h00;
`ifdef ORDER_CANCEL_EN
        cancel_valid = 1'b0;
        cancel_side  = 1'b0;
`endif

        // 1. Reset, then release
        repeat (3) step();
        chk("ready_in_reset", {31'd0, order_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_ready", {31'd0, order_ready}, 32'd1);
        chk("rst_bid", best_bid, 32'h00);
        chk("rst_ask", best_ask, 32'hFF);
        chk("rst_match", {31'd0, match_signal}, 32'd0);
        chk("rst_mcount", match_count, 32'd0);
        chk("rst_rcount", reject_count, 32'd0);

        // 2. Buy 100x5, then sell 98x3 -> trade 100/98 qty 3
        send(1'b0, 8'd100, 8'd5);
        chk("t2_bid", best_bid, 32'd100);
        chk("t2_bidq", bid_qty, 32'd5);
        chk("t2_ready_check", {31'd0, order_ready}, 32'd0);
        step();
        send(1'b1, 8'd98, 8'd3);
        chk("t2_no_match_check", {31'd0, match_signal}, 32'd0);
        step();
        chk("t2_match", {31'd0, match_signal}, 32'd1);
        chk("t2_buy_price", buy_price, 32'd100);
        chk("t2_sell_price", sell_price, 32'd98);
        chk("t2_match_qty", match_qty, 32'd3);
        step();
        chk("t2_pulse_end", {31'd0, match_signal}, 32'd0);
        chk("t2_bidq_after", bid_qty, 32'd2);
        chk("t2_bid_after", best_bid, 32'd100);
        chk("t2_ask_after", best_ask, 32'hFF);
        chk("t2_mcount", match_count, 32'd1);
        step();
        chk("t2_idle_ready", {31'd0, order_ready}, 32'd1);
        chk("t2_no_retrade", {31'd0, match_signal}, 32'd0);

        // Clear the residual bid with an equal-price sell (spread 0 trade)
        send(1'b1, 8'd100, 8'd2);
        step();
        chk("clr_match", {31'd0, match_signal}, 32'd1);
        chk("clr_prices", {16'd0, buy_price, sell_price}, 32'h6464);
        chk("clr_qty", match_qty, 32'd2);
        step();
        chk("clr_bid", best_bid, 32'h00);
        chk("clr_ask", best_ask, 32'hFF);
        chk("clr_mcount", match_count, 32'd2);
        step();

        // 3. Buy 50x4 + buy 50x6, then sell 50x10 -> single trade of 10
        send(1'b0, 8'd50, 8'd4);
        step();
        send(1'b0, 8'd50, 8'd6);
        chk("t3_bidq_acc", bid_qty, 32'd10);
        step();
        send(1'b1, 8'd50, 8'd10);
        step();
        chk("t3_match", {31'd0, match_signal}, 32'd1);
        chk("t3_buy_price", buy_price, 32'd50);
        chk("t3_sell_price", sell_price, 32'd50);
        chk("t3_match_qty", match_qty, 32'd10);
        step();
        chk("t3_bid", best_bid, 32'h00);
        chk("t3_ask", best_ask, 32'hFF);
        chk("t3_bidq", bid_qty, 32'd0);
        chk("t3_askq", ask_qty, 32'd0);
        chk("t3_mcount", match_count, 32'd3);
        step();
        chk("t3_single_trade", {31'd0, match_signal}, 32'd0);

        // 4. Rejects against a resting bid of 60
        send(1'b0, 8'd60, 8'd1);
        step();
        send(1'b0, 8'd0, 8'd3);
        send(1'b1, 8'hFF, 8'd3);
        send(1'b0, 8'd70, 8'd0);
        send(1'b0, 8'd40, 8'd2);
        chk("t4_rcount", reject_count, 32'd4);
        chk("t4_bid", best_bid, 32'd60);
        chk("t4_bidq", bid_qty, 32'd1);
        chk("t4_ask", best_ask, 32'hFF);
        chk("t4_match", {31'd0, match_signal}, 32'd0);
        chk("t4_mcount", match_count, 32'd3);

        // Quantity accumulation saturates: 1 + 255 -> 255
        send(1'b0, 8'd60, 8'hFF);
        chk("sat_bidq", bid_qty, 32'hFF);
        step();

        // 5. Reset asserted during the MATCH cycle
        send(1'b1, 8'd55, 8'd7);
        step();
        chk("t5_match", {31'd0, match_signal}, 32'd1);
        chk("t5_match_qty", match_qty, 32'd7);
        chk("t5_prices", {16'd0, buy_price, sell_price}, 32'h3C37);
        reset = 1'b0;
        step();
        chk("t5_match_cleared", {31'd0, match_signal}, 32'd0);
        chk("t5_mcount", match_count, 32'd0);
        chk("t5_rcount", reject_count, 32'd0);
        chk("t5_bid", best_bid, 32'h00);
        chk("t5_ask", best_ask, 32'hFF);
        chk("t5_qtys", {16'd0, bid_qty, ask_qty}, 32'd0);
        chk("t5_prices_rst", {16'd0, buy_price, sell_price}, 32'd0);
        chk("t5_ready_rst", {31'd0, order_ready}, 32'd0);
        reset = 1'b1;
        step();
        chk("t5_no_match_after", {31'd0, match_signal}, 32'd0);
        chk("t5_ready_after", {31'd0, order_ready}, 32'd1);

        // reject_count saturates at 255
        order_valid = 1'b1;
        order_side  = 1'b0;
        order_price = 8'd10;
        order_qty   = 8'd0;
        for (int i = 0; i < 260; i++) begin
            @(posedge clk);
        end
        #1;
        order_valid = 1'b0;
        chk("rcount_sat", reject_count, 32'd255);
        chk("rcount_book", best_bid, 32'h00);

`ifdef ORDER_CANCEL_EN
        // 6. Cancel beats a simultaneous order
        send(1'b0, 8'd70, 8'd2);
        step();
        cancel_valid = 1'b1;
        cancel_side  = 1'b0;
        order_valid  = 1'b1;
        order_side   = 1'b0;
        order_price  = 8'd30;
        order_qty    = 8'd4;
        #1;
        chk("t6_ready_blocked", {31'd0, order_ready}, 32'd0);
        step();
        cancel_valid = 1'b0;
        chk("t6_bid_cleared", best_bid, 32'h00);
        chk("t6_bidq_cleared", bid_qty, 32'd0);
        #1;
        chk("t6_ready_again", {31'd0, order_ready}, 32'd1);
        step();
        order_valid = 1'b0;
        chk("t6_order_taken", best_bid, 32'd30);
        chk("t6_order_qty", bid_qty, 32'd4);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
